// File: rtl/cpu_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_phase_sequencer
// Brief    : Fetch/execute beat sequencer with sticky stop, single-step hold
//            and instruction-retire pulse. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_phase_sequencer #(
    parameter int IF_BEATS = 2,
    parameter int EX_BEATS = 4,
    parameter int LEN_W    = $clog2(EX_BEATS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                RUN,
    input  logic                stop,
    input  logic                done,
    input  logic [LEN_W-1:0]    ex_len,
    input  logic                step_mode,
    input  logic                step,
    output logic                Mif,
    output logic                Mex,
    output logic [EX_BEATS-1:0] T,
    output logic [LEN_W-1:0]    beat,
    output logic                busy,
    output logic                halted,
    output logic                retire
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic               r_stop_pend;

    state_t             w_state_nxt;
    logic [LEN_W-1:0]   w_beat_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [LEN_W-1:0]   w_len_clamp;
    logic               w_pend_nxt;
    logic               w_pend_set;
    logic               w_retire_nxt;
    logic               w_start;
    logic [EX_BEATS-1:0] w_t_nxt;

    always_comb begin
        w_len_clamp = ex_len;
        if (ex_len == '0) begin
            w_len_clamp = LEN_W'(1);
        end else if (ex_len > LEN_W'(EX_BEATS)) begin
            w_len_clamp = LEN_W'(EX_BEATS);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_beat_nxt   = beat;
        w_len_nxt    = r_len;
        w_pend_nxt   = r_stop_pend;
        w_pend_set   = r_stop_pend | stop;
        w_retire_nxt = 1'b0;
        w_start      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (RUN && !stop) begin
                    w_state_nxt = S_FETCH;
                    w_beat_nxt  = '0;
                    w_start     = 1'b1;
                end
            end
            S_FETCH: begin
                w_pend_nxt = w_pend_set;
                if (done) begin
                    w_start = 1'b1;
                    if (beat == LEN_W'(IF_BEATS - 1)) begin
                        w_state_nxt = S_EXEC;
                        w_beat_nxt  = '0;
                        w_len_nxt   = w_len_clamp;
                    end else begin
                        w_beat_nxt = beat + LEN_W'(1);
                    end
                end
            end
            S_EXEC: begin
                w_pend_nxt = w_pend_set;
                if (done) begin
                    if (beat == r_len - LEN_W'(1)) begin
                        // Instruction boundary: stop beats step, step beats refetch
                        w_retire_nxt = 1'b1;
                        w_beat_nxt   = '0;
                        if (w_pend_set) begin
                            w_state_nxt = S_IDLE;
                        end else if (step_mode) begin
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_state_nxt = S_FETCH;
                            w_start     = 1'b1;
                        end
                    end else begin
                        w_beat_nxt = beat + LEN_W'(1);
                        w_start    = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (step) begin
                    w_state_nxt = S_FETCH;
                    w_beat_nxt  = '0;
                    w_start     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_beat_nxt  = '0;
            end
        endcase

        if (w_state_nxt == S_IDLE) begin
            w_pend_nxt = 1'b0;
        end

        w_t_nxt = w_start ? (EX_BEATS'(1) << w_beat_nxt) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= LEN_W'(1);
            r_stop_pend <= 1'b0;
            beat        <= '0;
            T           <= '0;
            Mif         <= 1'b0;
            Mex         <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            retire      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_stop_pend <= w_pend_nxt;
            beat        <= w_beat_nxt;
            T           <= w_t_nxt;
            Mif         <= (w_state_nxt == S_FETCH);
            Mex         <= (w_state_nxt == S_EXEC);
            busy        <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_EXEC);
            halted      <= (w_state_nxt == S_HOLD);
            retire      <= w_retire_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_phase_sequencer
// Brief    : Directed self-checking bench for cpu_phase_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_phase_sequencer;

    logic       clk;
    logic       rst_n;
    logic       RUN;
    logic       stop;
    logic       done;
    logic [2:0] ex_len;
    logic       step_mode;
    logic       step;
    logic       Mif;
    logic       Mex;
    logic [3:0] T;
    logic [2:0] beat;
    logic       busy;
    logic       halted;
    logic       retire;

    int checks = 0;
    int errors = 0;

    cpu_phase_sequencer #(
        .IF_BEATS(2),
        .EX_BEATS(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RUN       (RUN),
        .stop      (stop),
        .done      (done),
        .ex_len    (ex_len),
        .step_mode (step_mode),
        .step      (step),
        .Mif       (Mif),
        .Mex       (Mex),
        .T         (T),
        .beat      (beat),
        .busy      (busy),
        .halted    (halted),
        .retire    (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {Mif, Mex, busy, halted, retire, T[3:0], beat[2:0]}
    function automatic logic [11:0] snap();
        return {Mif, Mex, busy, halted, retire, T, beat};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bit ok;
        ok   = 1'b0;
        RUN  = 1'b0;
        done = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (!busy && !halted) ok = 1'b1;
            else tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL go_idle: busy=%0b halted=%0b, required 0/0 within 20 cycles", busy, halted);
        end
    endtask

    task automatic test_reset();
        logic [11:0] o;
        rst_n = 1'b0; RUN = 0; stop = 0; done = 0; ex_len = 0; step_mode = 0; step = 0;
        tick(); tick();
        o = snap();
        checks++;
        if (o !== 12'b0_0_0_0_0_0000_000) begin
            errors++; $display("FAIL reset_state: got %b required %b", o, 12'b0);
        end
        rst_n = 1'b1;
        tick();
        o = snap();
        checks++;
        if (o !== 12'b0) begin
            errors++; $display("FAIL idle_after_reset: got %b required %b", o, 12'b0);
        end
    endtask

    task automatic test_basic();
        logic [11:0] o;
        logic [11:0] exp_v [8];
        exp_v = '{12'b1_0_1_0_0_0001_000, 12'b1_0_1_0_0_0010_001,
                  12'b0_1_1_0_0_0001_000, 12'b0_1_1_0_0_0010_001,
                  12'b1_0_1_0_1_0001_000, 12'b1_0_1_0_0_0010_001,
                  12'b0_1_1_0_0_0001_000, 12'b0_1_1_0_0_0010_001};
        done = 1; ex_len = 3'd2; RUN = 1;
        tick();
        RUN = 0;
        for (int i = 0; i < 8; i++) begin
            o = snap();
            checks++;
            if (o !== exp_v[i] || (Mif && Mex)) begin
                errors++; $display("FAIL basic_cycle%0d: got %b required %b", i, o, exp_v[i]);
            end
            tick();
        end
        go_idle();
    endtask

    task automatic test_clamp();
        logic [11:0] o;
        done = 1; ex_len = 3'd0; RUN = 1;
        tick(); RUN = 0;      // F0
        tick();               // F1
        tick();               // E0, len clamped to 1
        ex_len = 3'd7;
        o = snap(); checks++;
        if (o !== 12'b0_1_1_0_0_0001_000) begin
            errors++; $display("FAIL clamp0_exec: got %b required %b", o, 12'b0_1_1_0_0_0001_000);
        end
        tick();
        o = snap(); checks++;
        if (o !== 12'b1_0_1_0_1_0001_000) begin
            errors++; $display("FAIL clamp0_retire: got %b required %b", o, 12'b1_0_1_0_1_0001_000);
        end
        tick();               // F1
        tick();               // E0, len clamped to 4
        ex_len = 3'd0;
        tick(); tick(); tick();
        o = snap(); checks++;
        if (o !== 12'b0_1_1_0_0_1000_011) begin
            errors++; $display("FAIL clamp7_beat4: got %b required %b", o, 12'b0_1_1_0_0_1000_011);
        end
        tick();
        o = snap(); checks++;
        if (o !== 12'b1_0_1_0_1_0001_000) begin
            errors++; $display("FAIL clamp7_retire: got %b required %b", o, 12'b1_0_1_0_1_0001_000);
        end
        go_idle();
    endtask

    task automatic test_stall();
        logic [11:0] o;
        done = 1; ex_len = 3'd3; RUN = 1;
        tick(); RUN = 0;
        tick(); tick(); tick();   // E1
        o = snap(); checks++;
        if (o !== 12'b0_1_1_0_0_0010_001) begin
            errors++; $display("FAIL stall_entry: got %b required %b", o, 12'b0_1_1_0_0_0010_001);
        end
        done = 0;
        tick();
        o = snap(); checks++;
        if (o !== 12'b0_1_1_0_0_0000_001) begin
            errors++; $display("FAIL stall_hold1: got %b required %b", o, 12'b0_1_1_0_0_0000_001);
        end
        tick();
        done = 1;
        o = snap(); checks++;
        if (o !== 12'b0_1_1_0_0_0000_001) begin
            errors++; $display("FAIL stall_hold2: got %b required %b", o, 12'b0_1_1_0_0_0000_001);
        end
        tick();
        o = snap(); checks++;
        if (o !== 12'b0_1_1_0_0_0100_010) begin
            errors++; $display("FAIL stall_advance: got %b required %b", o, 12'b0_1_1_0_0_0100_010);
        end
        go_idle();
    endtask

    task automatic test_stop();
        logic [11:0] o;
        done = 1; ex_len = 3'd3; RUN = 1;
        tick(); RUN = 0; stop = 1;   // F0
        tick(); stop = 0;            // F1
        tick(); tick(); tick();      // E2
        o = snap(); checks++;
        if (o !== 12'b0_1_1_0_0_0100_010) begin
            errors++; $display("FAIL stop_completes: got %b required %b", o, 12'b0_1_1_0_0_0100_010);
        end
        tick();
        o = snap(); checks++;
        if (o !== 12'b0_0_0_0_1_0000_000) begin
            errors++; $display("FAIL stop_retire_idle: got %b required %b", o, 12'b0_0_0_0_1_0000_000);
        end
        tick();
        o = snap(); checks++;
        if (o !== 12'b0) begin
            errors++; $display("FAIL stop_stays_idle: got %b required %b", o, 12'b0);
        end
        RUN = 1;
        tick(); RUN = 0;
        o = snap(); checks++;
        if (o !== 12'b1_0_1_0_0_0001_000) begin
            errors++; $display("FAIL stop_restart: got %b required %b", o, 12'b1_0_1_0_0_0001_000);
        end
        go_idle();
    endtask

    task automatic test_step();
        logic [11:0] o;
        done = 1; ex_len = 3'd1; step_mode = 1; RUN = 1;
        tick(); RUN = 0;
        tick(); tick(); tick();
        o = snap(); checks++;
        if (o !== 12'b0_0_0_1_1_0000_000) begin
            errors++; $display("FAIL step_hold_entry: got %b required %b", o, 12'b0_0_0_1_1_0000_000);
        end
        RUN = 1;
        tick();
        RUN = 0;
        o = snap(); checks++;
        if (o !== 12'b0_0_0_1_0_0000_000) begin
            errors++; $display("FAIL step_hold_stays: got %b required %b", o, 12'b0_0_0_1_0_0000_000);
        end
        step = 1;
        tick(); step = 0;
        o = snap(); checks++;
        if (o !== 12'b1_0_1_0_0_0001_000) begin
            errors++; $display("FAIL step_release: got %b required %b", o, 12'b1_0_1_0_0_0001_000);
        end
        tick(); tick(); tick();
        o = snap(); checks++;
        if (o !== 12'b0_0_0_1_1_0000_000) begin
            errors++; $display("FAIL step_hold_again: got %b required %b", o, 12'b0_0_0_1_1_0000_000);
        end
        stop = 1; step = 1;
        tick(); stop = 0; step = 0; step_mode = 0;
        o = snap(); checks++;
        if (o !== 12'b0) begin
            errors++; $display("FAIL step_stop_priority: got %b required %b", o, 12'b0);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] o;
        done = 1; ex_len = 3'd4; RUN = 1;
        tick(); RUN = 0;
        tick(); tick(); tick(); tick();   // E2
        o = snap(); checks++;
        if (o !== 12'b0_1_1_0_0_0100_010) begin
            errors++; $display("FAIL rstmid_pre: got %b required %b", o, 12'b0_1_1_0_0_0100_010);
        end
        #2 rst_n = 0;
        #1;
        o = snap(); checks++;
        if (o !== 12'b0) begin
            errors++; $display("FAIL rstmid_async: got %b required %b", o, 12'b0);
        end
        rst_n = 1; RUN = 1; stop = 1;
        tick();
        o = snap(); checks++;
        if (o !== 12'b0) begin
            errors++; $display("FAIL rstmid_stop_wins: got %b required %b", o, 12'b0);
        end
        stop = 0;
        tick(); RUN = 0;
        o = snap(); checks++;
        if (o !== 12'b1_0_1_0_0_0001_000) begin
            errors++; $display("FAIL rstmid_restart: got %b required %b", o, 12'b1_0_1_0_0_0001_000);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_stall();
        test_stop();
        test_step();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_phase_sequencer.md
# cpu_phase_sequencer

Parametrised machine-cycle/beat sequencer for the simple CPU. It steps the control unit through a configurable number of fetch beats, then a per-instruction number of execute beats. For each beat it produces fetch/execute cycle flags and a single-cycle one-hot beat-entry pulse. It adds a sticky stop request, single-step mode with a hold state, and an instruction-retire pulse. It sits between the front-panel/run-control logic and the microcode/control-signal decoder.

## Interface
- IF_BEATS, 2: fetch beats per instruction; 1 ≤ IF_BEATS ≤ EX_BEATS.
- EX_BEATS, 4: maximum execute beats per instruction; also the width of T.
- LEN_W, $clog2(EX_BEATS+1): width of ex_len.
- Clock/reset: one clock; reset is asynchronous and active-low. The ports are named clk and rst_n.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- RUN  in  1  start request, level-sampled in IDLE.
- stop  in  1  stop request, sampled every cycle.
- done  in  1  current beat complete; advance at this edge.
- ex_len  in  LEN_W  execute beat count for the current instruction.
- step_mode  in  1  single-step enable.
- step  in  1  release from HOLD, level-sampled.
- Mif  out  1  high during fetch beats.
- Mex  out  1  high during execute beats.
- T  out  EX_BEATS  one-hot beat-entry pulse; bit k means beat k+1.
- beat  out  LEN_W  current beat index, 0-based; 0 when not busy.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HOLD.
- retire  out  1  one-cycle pulse after an instruction completes.

## Operation
- States: IDLE, FETCH, EXEC, HOLD. State register and all outputs are registered and updated together.
- IDLE:
  - RUN=1 and stop=0 → FETCH beat 0.
  - stop=1 → stay in IDLE. stop wins over RUN.
- FETCH beat k:
  - done=1 with k < IF_BEATS-1 → beat k+1.
  - done=1 with k = IF_BEATS-1 → EXEC beat 0.
  - On the last-fetch-beat done, latch ex_len into len_q, clamped: 0→1, >EX_BEATS→EX_BEATS.
- EXEC beat k:
  - done=1 with k < len_q-1 → beat k+1.
  - done=1 with k = len_q-1 → instruction boundary.
- Instruction boundary: assert retire next cycle, then take the first matching exit:
  - stop_pend=1 → IDLE.
  - step_mode=1 → HOLD.
  - otherwise → FETCH beat 0.
- HOLD:
  - stop=1 → IDLE. This has priority over step.
  - step=1 → FETCH beat 0.
  - RUN is ignored.
- stop_pend:
  - Set when stop=1 in FETCH or EXEC. A stop during an instruction never aborts it; it takes effect at the boundary.
  - Cleared on entry to IDLE.
  - stop in the same cycle as the final done counts, so that boundary goes to IDLE.
- RUN while busy or in HOLD is ignored.
- done in IDLE or HOLD is ignored.
- Mif=1 exactly when in FETCH. Mex=1 exactly when in EXEC. Never both.
- T: bit `beat` is high only in the first cycle of each beat. T is all-zero otherwise, including in IDLE and HOLD.
- step_mode changes take effect only at the next boundary.

## Timing
- Reset (async assert): state=IDLE; Mif=Mex=busy=halted=retire=0; T=0; beat=0; len_q=1; stop_pend=0.
- Reset deassertion is synchronous to clk by the integrator; the first active edge may start a run.
- RUN sampled high at edge n → in cycle n+1: Mif=1, T[0]=1, beat=0, busy=1.
- Each beat lasts ≥1 cycle; it ends at the edge where done=1.
- With done held high, a new beat begins every cycle and a T bit pulses every cycle.
- The last EX done at edge n:
  - cycle n+1: retire=1, together with the next state (T[0]=1 and Mif=1 if refetching).
  - if the next state is IDLE or HOLD, busy=0 in cycle n+1.
- Minimum instruction length is IF_BEATS+1 cycles. With the defaults, full back-to-back throughput is 3–6 cycles per instruction.
- ex_len is don't-care except at the last-fetch-beat done edge.
- Asynchronous reset mid-beat returns to IDLE immediately and discards len_q and stop_pend.

## Test plan
- Defaults, done=1 constantly, ex_len=2, RUN pulse:
  - T sequence is 01,10 (Mif), then 01,10 (Mex); retire, then repeat every 4 cycles.
  - Mif/Mex are never both high.
- ex_len=0, then ex_len=7:
  - Exactly 1 EX beat, then exactly 4 EX beats (clamp).
  - ex_len changed mid-EXEC has no effect.
- done stalled for 3 cycles in EX beat 2:
  - T[1] high only in the first of those cycles; beat=1 held.
  - Advances the cycle after done.
- stop pulsed in FETCH beat 0 with ex_len=3:
  - The instruction completes all 3 EX beats, retire=1, then IDLE.
  - A later RUN restarts at FETCH beat 0.
- step_mode=1:
  - After retire: halted=1 and T=0 until step.
  - step → T[0] and Mif the next cycle.
  - stop together with step in HOLD → IDLE.
- Reset asserted during EX beat 3:
  - All outputs 0 immediately.
  - RUN and stop both high in IDLE → stays IDLE.
